io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Two-requester arbiter placed between the CPU data port and the IO controller / data-memory bus. It shares the single bus between the CPU and a monitor port, which a debug loader or result dumper uses to read or write memory and IO registers while the CPU runs. The CPU wins by default. A streak counter guarantees the monitor a slot after a bounded number of contended CPU cycles. Monitor reads are returned registered, and CPU stalls are counted for the cycle-count display path.

## Interface
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width
- MAX_STREAK, 4, number of consecutive contended CPU wins before the monitor is forced through; legal range 1..15
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cpuReq  in  1  CPU performs a data access this cycle
- cpuAddr  in  ADDR_WIDTH  CPU address
- cpuWData  in  DATA_WIDTH  CPU write data
- cpuWe  in  1  CPU write enable
- cpuStall  out  1  CPU access not performed this cycle; CPU holds all inputs and retries
- cpuRData  out  DATA_WIDTH  read data for the CPU, same cycle
- monReq  in  1  monitor request; once raised, held with stable addr/data/we until monGnt
- monAddr  in  ADDR_WIDTH  monitor address
- monWData  in  DATA_WIDTH  monitor write data
- monWe  in  1  monitor write enable
- monGnt  out  1  monitor access performed this cycle
- monRData  out  DATA_WIDTH  registered monitor read data
- monRValid  out  1  one-cycle pulse; monRData valid
- busAddr  out  ADDR_WIDTH  to IO controller
- busWData  out  DATA_WIDTH  to IO controller
- busWe  out  1  to IO controller
- busRData  in  DATA_WIDTH  combinational read data from IO controller
- stallCount  out  16  saturating count of cycles with cpuStall=1

## Operation
- Owner selection is combinational from the request inputs and the registered streak:
  - neither request: no owner; busWe=0, busAddr=cpuAddr, busWData=cpuWData.
  - cpuReq only: CPU owns the bus.
  - monReq only: monitor owns the bus; monGnt=1.
  - both requests, streak<MAX_STREAK: CPU owns the bus.
  - both requests, streak==MAX_STREAK: monitor owns the bus; monGnt=1, cpuStall=1.
- Bus mux: the owner's addr/wdata/we drive busAddr/busWData/busWe. cpuStall=1 forces the CPU's write off the bus.
- cpuRData=busRData at all times. Its value is only meaningful when the CPU owns the bus.
- Streak register, width 4:
  - cleared when monGnt=1 or monReq=0.
  - incremented when the CPU wins while monReq=1.
  - never exceeds MAX_STREAK.
- Read return: when monGnt=1 and monWe=0, busRData is captured into monRData and monRValid pulses on the next cycle. A monitor write produces no monRValid. monRData holds its value until the next capture.
- stallCount increments on every cycle with cpuStall=1 and saturates at 16'hFFFF.
- Dropping monReq before monGnt is a protocol violation with undefined behaviour. The bench asserts it never happens.

## Timing
- Reset values: streak=0, monRValid=0, monRData=0, stallCount=0.
- While rst=1, monGnt=0, cpuStall=0 and busWe=0. These outputs are gated by rst.
- Grant, stall and the bus mux have zero-cycle latency. monRData/monRValid have one-cycle latency.
- Monitor worst-case wait under continuous CPU traffic is MAX_STREAK cycles; the grant comes on cycle MAX_STREAK+1.
- After a forced monitor slot, streak=0, so the CPU retry on the next cycle always wins.
- Back-to-back monitor requests under contention: each one waits a fresh MAX_STREAK cycles.
- Reset mid-operation: a read granted in the cycle before rst rises produces no monRValid. The streak clears immediately.
- A monitor read and its monRValid pulse can overlap the next monitor grant; monRData updates every cycle a read is granted.

## Test plan
- CPU-only traffic, 10 cycles with cpuReq=1, monReq=0, cpuAddr=0x10 -> busAddr=0x10 every cycle, cpuStall=0, stallCount=0.
- Monitor-only read of 0x80 with busRData=0x1234 -> monGnt=1 on the request cycle; next cycle monRValid=1, monRData=0x1234.
- Contention, MAX_STREAK=4, both requests held -> CPU wins cycles 1-4; cycle 5 monGnt=1, cpuStall=1, busAddr=monAddr; cycle 6 CPU wins; stallCount=1.
- Contended monitor write (monWe=1, monWData=0xA5) alongside a CPU write (cpuWe=1) -> only the monitor write reaches the bus on its grant cycle (busWData=0xA5, busWe=1); no monRValid.
- rst pulse asserted during a contended wait at streak=3 -> outputs reach reset values immediately; after release, contention restarts at streak 0 and monGnt arrives 4 cycles later.
- Force 65540 stall cycles -> stallCount saturates at 0xFFFF.

Source files
------------

// File: rtl/io_bus_arbiter_if.sv
// Shared bus bundle between the CPU data port, the monitor port and the IO controller.
// The master side drives requests and the IO read data; the slave side is the arbiter.
interface io_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpuReq;
  logic [ADDR_WIDTH-1:0] cpuAddr;
  logic [DATA_WIDTH-1:0] cpuWData;
  logic                  cpuWe;
  logic                  cpuStall;
  logic [DATA_WIDTH-1:0] cpuRData;
  logic                  monReq;
  logic [ADDR_WIDTH-1:0] monAddr;
  logic [DATA_WIDTH-1:0] monWData;
  logic                  monWe;
  logic                  monGnt;
  logic [DATA_WIDTH-1:0] monRData;
  logic                  monRValid;
  logic [ADDR_WIDTH-1:0] busAddr;
  logic [DATA_WIDTH-1:0] busWData;
  logic                  busWe;
  logic [DATA_WIDTH-1:0] busRData;
  logic [15:0]           stallCount;

  modport master (
    output cpuReq, cpuAddr, cpuWData, cpuWe, monReq, monAddr, monWData, monWe, busRData,
    input  cpuStall, cpuRData, monGnt, monRData, monRValid, busAddr, busWData, busWe, stallCount
  );

  modport slave (
    input  cpuReq, cpuAddr, cpuWData, cpuWe, monReq, monAddr, monWData, monWe, busRData,
    output cpuStall, cpuRData, monGnt, monRData, monRValid, busAddr, busWData, busWe, stallCount
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// CPU/monitor arbiter for the shared IO bus: CPU-priority with a streak limit that
// guarantees the monitor a slot, registered monitor read return and a stall counter.
module io_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STREAK = 4
) (
  input logic            clk,
  input logic            rst,
  io_bus_arbiter_if.slave io
);
  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);

  logic [3:0]            streak_r;
  logic                  monOwner_s;
  logic                  cpuOwner_s;
  logic [ADDR_WIDTH-1:0] busAddr_s;
  logic [DATA_WIDTH-1:0] busWData_s;
  logic                  busWe_s;
  logic [DATA_WIDTH-1:0] monRData_r;
  logic                  monRValid_r;
  logic [15:0]           stallCount_r;

  // Owner selection; reset forces no owner so grant, stall and bus write stay low.
  always_comb begin
    monOwner_s = 1'b0;
    cpuOwner_s = 1'b0;
    if (rst) begin
      monOwner_s = 1'b0;
      cpuOwner_s = 1'b0;
    end else if (io.monReq && (!io.cpuReq || (streak_r == STREAK_LIMIT))) begin
      monOwner_s = 1'b1;
    end else if (io.cpuReq) begin
      cpuOwner_s = 1'b1;
    end else begin
      monOwner_s = 1'b0;
      cpuOwner_s = 1'b0;
    end
  end

  // Bus mux; an idle bus still presents the CPU address with writes disabled.
  always_comb begin
    busAddr_s  = io.cpuAddr;
    busWData_s = io.cpuWData;
    busWe_s    = 1'b0;
    if (monOwner_s) begin
      busAddr_s  = io.monAddr;
      busWData_s = io.monWData;
      busWe_s    = io.monWe;
    end else if (cpuOwner_s) begin
      busWe_s    = io.cpuWe;
    end else begin
      busWe_s    = 1'b0;
    end
  end

  assign io.busAddr    = busAddr_s;
  assign io.busWData   = busWData_s;
  assign io.busWe      = busWe_s;
  assign io.monGnt     = monOwner_s;
  assign io.cpuStall   = monOwner_s & io.cpuReq;
  assign io.cpuRData   = io.busRData;
  assign io.monRData   = monRData_r;
  assign io.monRValid  = monRValid_r;
  assign io.stallCount = stallCount_r;

  // Streak of contended CPU wins; a monitor grant or an idle monitor restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_r <= 4'd0;
    end else if (!io.monReq || monOwner_s) begin
      streak_r <= 4'd0;
    end else if (cpuOwner_s && (streak_r != STREAK_LIMIT)) begin
      streak_r <= streak_r + 4'd1;
    end else begin
      streak_r <= streak_r;
    end
  end

  // Monitor read return, one cycle after the granted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      monRValid_r <= 1'b0;
      monRData_r  <= {DATA_WIDTH{1'b0}};
    end else if (monOwner_s && !io.monWe) begin
      monRValid_r <= 1'b1;
      monRData_r  <= io.busRData;
    end else begin
      monRValid_r <= 1'b0;
      monRData_r  <= monRData_r;
    end
  end

  // Saturating count of stalled CPU cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount_r <= 16'd0;
    end else if (io.cpuStall && (stallCount_r != 16'hFFFF)) begin
      stallCount_r <= stallCount_r + 16'd1;
    end else begin
      stallCount_r <= stallCount_r;
    end
  end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a rule-level reference model of the arbitration.
module tb_io_bus_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc();
  io_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STREAK(MAXS)) dut (
    .clk(clk),
    .rst(rst),
    .io (ifc)
  );

  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;

  // Reference model state: cycles the pending monitor request has been refused,
  // expected read-return registers and the expected stall count.
  int          waited;
  logic        expRValid;
  logic [31:0] expRData;
  int          expStall;
  logic        lastGrant;
  logic        monPending;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    waited    = 0;
    expRValid = 1'b0;
    expRData  = 32'd0;
    expStall  = 0;
    lastGrant = 1'b0;
  endtask

  // One clock cycle with the inputs currently applied: check outputs mid-cycle, then advance the model.
  task automatic cycle();
    logic        grant, stall, expWe, nRValid;
    logic [31:0] expAddr, expWData, nRData;
    int          nWaited, nStall;
    @(negedge clk);
    grant    = !rst && ifc.monReq && (!ifc.cpuReq || waited >= MAXS);
    stall    = grant && ifc.cpuReq;
    expAddr  = grant ? ifc.monAddr  : ifc.cpuAddr;
    expWData = grant ? ifc.monWData : ifc.cpuWData;
    expWe    = grant ? ifc.monWe : (!rst && ifc.cpuReq && ifc.cpuWe);
    check("monGnt",     32'(ifc.monGnt),     32'(grant));
    check("cpuStall",   32'(ifc.cpuStall),   32'(stall));
    check("busAddr",    ifc.busAddr,         expAddr);
    check("busWData",   ifc.busWData,        expWData);
    check("busWe",      32'(ifc.busWe),      32'(expWe));
    check("cpuRData",   ifc.cpuRData,        ifc.busRData);
    check("monRValid",  32'(ifc.monRValid),  32'(expRValid));
    check("monRData",   ifc.monRData,        expRData);
    check("stallCount", 32'(ifc.stallCount), 32'(expStall));
    nWaited = (!rst && ifc.monReq && !grant) ? waited + 1 : 0;
    nRValid = grant && !ifc.monWe;
    nRData  = nRValid ? ifc.busRData : expRData;
    nStall  = (stall && expStall < 65535) ? expStall + 1 : expStall;
    @(posedge clk);
    #1;
    if (rst) begin
      resetModel();
    end else begin
      waited    = nWaited;
      expRValid = nRValid;
      expRData  = nRData;
      expStall  = nStall;
      lastGrant = grant;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".monGnt"},     32'(ifc.monGnt),     32'd0);
    check({tag, ".cpuStall"},   32'(ifc.cpuStall),   32'd0);
    check({tag, ".busWe"},      32'(ifc.busWe),      32'd0);
    check({tag, ".monRValid"},  32'(ifc.monRValid),  32'd0);
    check({tag, ".monRData"},   ifc.monRData,        32'd0);
    check({tag, ".stallCount"}, 32'(ifc.stallCount), 32'd0);
  endtask

  // Protocol guard on the bench's own stimulus: a pending monitor request is never withdrawn.
  logic protoReq = 1'b0;
  logic protoGnt = 1'b0;
  always @(negedge clk) begin
    if (!rst && protoReq && !protoGnt) begin
      assert (ifc.monReq) else $error("protocol: monReq dropped before monGnt");
    end
    protoReq <= ifc.monReq;
    protoGnt <= ifc.monGnt;
  end

  initial begin
    rst = 1'b1;
    ifc.cpuReq = 1'b0;  ifc.cpuAddr = 32'd0;  ifc.cpuWData = 32'd0;  ifc.cpuWe = 1'b0;
    ifc.monReq = 1'b0;  ifc.monAddr = 32'd0;  ifc.monWData = 32'd0;  ifc.monWe = 1'b0;
    ifc.busRData = 32'd0;
    monPending = 1'b0;
    resetModel();
    #1;
    checkResetOutputs("reset");
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;

    // CPU-only traffic
    ifc.cpuReq = 1'b1;
    ifc.cpuAddr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      ifc.cpuWData = $urandom;
      ifc.cpuWe    = 1'($urandom_range(0, 1));
      ifc.busRData = $urandom;
      cycle();
    end
    check("cpuOnly.stallCount", 32'(ifc.stallCount), 32'd0);

    // Monitor-only read
    ifc.cpuReq = 1'b0;  ifc.cpuWe = 1'b0;
    ifc.monReq = 1'b1;  ifc.monAddr = 32'h80;  ifc.monWe = 1'b0;
    ifc.busRData = 32'h1234;
    cycle();
    ifc.monReq = 1'b0;
    ifc.busRData = 32'h5555;
    check("monRead.rvalid", 32'(ifc.monRValid), 32'd1);
    check("monRead.rdata",  ifc.monRData,       32'h1234);
    cycle();

    // Contended read: four CPU wins, forced monitor slot, CPU retry wins
    ifc.cpuReq = 1'b1;  ifc.cpuAddr = 32'h20;  ifc.cpuWe = 1'b0;
    ifc.monReq = 1'b1;  ifc.monAddr = 32'h90;  ifc.monWe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ifc.busRData = $urandom;
      cycle();
    end
    ifc.monReq = 1'b0;
    cycle();
    check("contend.stallCount", 32'(ifc.stallCount), 32'd1);

    // Contended monitor write alongside a CPU write
    ifc.cpuReq = 1'b1;  ifc.cpuWe = 1'b1;  ifc.cpuWData = 32'hDEAD;
    ifc.monReq = 1'b1;  ifc.monWe = 1'b1;  ifc.monWData = 32'hA5;  ifc.monAddr = 32'hC0;
    for (int i = 0; i < 5; i++) cycle();
    ifc.monReq = 1'b0;
    cycle();
    check("write.noRValid", 32'(ifc.monRValid), 32'd0);

    // Read granted just before reset rises produces no read return
    ifc.cpuReq = 1'b0;  ifc.cpuWe = 1'b0;
    ifc.monReq = 1'b1;  ifc.monWe = 1'b0;  ifc.busRData = 32'hBEEF;
    cycle();
    ifc.monReq = 1'b0;
    rst = 1'b1;
    #1;
    resetModel();
    checkResetOutputs("rstAfterRead");
    cycle();
    rst = 1'b0;

    // Reset during a contended wait at streak 3, then a fresh full wait
    ifc.cpuReq = 1'b1;  ifc.cpuWe = 1'b1;
    ifc.monReq = 1'b1;  ifc.monWe = 1'b0;  ifc.monAddr = 32'hA0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    #1;
    resetModel();
    checkResetOutputs("rstMidWait");
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("rstMidWait.regrant", 32'(lastGrant), 32'd1);
    ifc.monReq = 1'b0;
    cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ifc.cpuReq   = ($urandom_range(0, 3) != 32'd0);
      ifc.cpuWe    = 1'($urandom_range(0, 1));
      ifc.cpuAddr  = $urandom;
      ifc.cpuWData = $urandom;
      ifc.busRData = $urandom;
      if (!monPending && $urandom_range(0, 2) == 32'd0) begin
        monPending   = 1'b1;
        ifc.monReq   = 1'b1;
        ifc.monAddr  = $urandom;
        ifc.monWData = $urandom;
        ifc.monWe    = 1'($urandom_range(0, 1));
      end else if (!monPending) begin
        ifc.monReq = 1'b0;
      end
      cycle();
      if (lastGrant) monPending = 1'b0;
    end

    // Stall counter saturation, starting just below the ceiling
    ifc.cpuReq = 1'b1;
    ifc.monReq = 1'b1;
    ifc.monWe  = 1'b0;
    force dut.stallCount_r = 16'hFFFC;
    #1;
    release dut.stallCount_r;
    expStall = 65532;
    for (int i = 0; i < 30; i++) cycle();
    check("saturate.stallCount", 32'(ifc.stallCount), 32'h0000FFFF);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
